tile_pixel_fetch: RTL and testbench

- Upstream stage of the VGA color mapper; feeds it the per-pixel shape code (export_pattern) and 2-bit color index (extend_color).
- Takes the VGA controller's DrawX/DrawY and a pixel strobe, then reads an 80x60 tile map and a 2bpp 8x8 pattern memory, both synchronous, one tile ahead of the beam.
- Presents registered per-pixel outputs aligned to the sampled DrawX.

---
 rtl/tile_pkg.sv | 26 ++
 rtl/tile_row_fetch.sv | 115 +++++++++++
 rtl/tile_pixel_fetch.sv | 133 +++++++++++++
 tb/tb_tile_pixel_fetch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants and FSM state type for the tile pixel fetch pipeline.
// TILE_HFLIP_EN widens the tile-map data word to carry a horizontal-mirror bit.
package tile_pkg;

   localparam int unsigned H_TOTAL  = 800;
   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_TOTAL  = 525;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned TILE_W   = 8;
   localparam int unsigned MAP_COLS = 80;
   localparam int unsigned MAP_ROWS = 60;

`ifdef TILE_HFLIP_EN
   localparam int unsigned MAP_DW = 9;
`else
   localparam int unsigned MAP_DW = 8;
`endif

   typedef enum logic [1:0] {
      IDLE,
      MAP_REQ,
      PAT_REQ,
      PAT_CAP
   } fetch_state_t;

endpackage

// File: rtl/tile_row_fetch.sv
// One-tile-ahead fetcher: tile-map read, pattern-row read, stage registers.
// TILE_HFLIP_EN captures map_rdata[8] as the stage mirror bit.
module tile_row_fetch
   import tile_pkg::*;
#(
   parameter logic [12:0] MAP_BASE = 13'd0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req,
   input  logic [6:0]        i_col,
   input  logic [8:0]        i_line,
   input  logic              i_stage_clr,
   input  logic [MAP_DW-1:0] i_map_rdata,
   input  logic [15:0]       i_pat_rdata,
   output logic              o_busy,
   output logic [12:0]       o_map_addr,
   output logic [10:0]       o_pat_addr,
   output logic [15:0]       o_stage_row,
   output logic [7:0]        o_stage_code,
   output logic              o_stage_flip,
   output logic              o_stage_valid
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic        w_map_ld;
   logic        w_code_ld;
   logic        w_stage_ld;
   logic [2:0]  r_row;
   logic [12:0] r_map_addr;
   logic [10:0] r_pat_addr;
   logic [7:0]  r_code;
   logic        r_flip;
   logic [12:0] w_tile_row;
   logic [12:0] w_map_addr;
   logic [10:0] w_pat_addr;
   logic        w_flip_bit;

   // tile_row * 80 as (r << 6) + (r << 4); the 13-bit sum wraps
   assign w_tile_row = {7'd0, i_line[8:3]};
   assign w_map_addr = MAP_BASE + (w_tile_row << 6) + (w_tile_row << 4) + {6'd0, i_col};
   assign w_pat_addr = {i_map_rdata[7:0], r_row};

`ifdef TILE_HFLIP_EN
   assign w_flip_bit = i_map_rdata[8];
`else
   assign w_flip_bit = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (i_req) w_state_nxt = MAP_REQ;
         MAP_REQ: w_state_nxt = PAT_REQ;
         PAT_REQ: w_state_nxt = PAT_CAP;
         PAT_CAP: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy     = (r_state != IDLE);
      w_map_ld   = (r_state == IDLE) && i_req;
      w_code_ld  = (r_state == PAT_REQ);
      w_stage_ld = (r_state == PAT_CAP);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_row         <= 3'd0;
         r_map_addr    <= 13'd0;
         r_pat_addr    <= 11'd0;
         r_code        <= 8'd0;
         r_flip        <= 1'b0;
         o_stage_row   <= 16'd0;
         o_stage_code  <= 8'd0;
         o_stage_flip  <= 1'b0;
         o_stage_valid <= 1'b0;
      end else begin
         if (w_map_ld) begin
            r_row      <= i_line[2:0];
            r_map_addr <= w_map_addr;
         end
         if (w_code_ld) begin
            r_code     <= i_map_rdata[7:0];
            r_flip     <= w_flip_bit;
            r_pat_addr <= w_pat_addr;
         end
         // A fresh row takes priority over a same-cycle consume
         if (w_stage_ld) begin
            o_stage_row   <= i_pat_rdata;
            o_stage_code  <= r_code;
            o_stage_flip  <= r_flip;
            o_stage_valid <= 1'b1;
         end else if (i_stage_clr) begin
            o_stage_valid <= 1'b0;
         end
      end
   end

   assign o_map_addr = r_map_addr;
   // Pattern address comes straight from map_rdata so the row lands in PAT_CAP
   assign o_pat_addr = (r_state == PAT_REQ) ? w_pat_addr : r_pat_addr;

endmodule

// File: rtl/tile_pixel_fetch.sv
// Beam-following tile/pattern fetch feeding the VGA color mapper.
// TILE_HFLIP_EN adds a per-tile horizontal mirror taken from map_rdata[8].
module tile_pixel_fetch
   import tile_pkg::*;
#(
   parameter logic [12:0] MAP_BASE   = 13'd0,
   parameter int unsigned PREFETCH_X = 792
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              pix_en,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   output logic [12:0]       map_addr,
   input  logic [MAP_DW-1:0] map_rdata,
   output logic [10:0]       pat_addr,
   input  logic [15:0]       pat_rdata,
   output logic [1:0]        extend_color,
   output logic [7:0]        export_pattern,
   output logic              pix_valid,
   output logic              underrun
);

   localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] X_TRIG   = 10'(H_ACTIVE - TILE_W);
   localparam logic [9:0] X_PRE    = 10'(PREFETCH_X);
   localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);

   logic        w_trig_a;
   logic        w_trig_b;
   logic        w_trig;
   logic [9:0]  w_next_line;
   logic [6:0]  w_req_col;
   logic [8:0]  w_req_line;
   logic        w_busy;
   logic        w_drop;
   logic        w_active;
   logic        w_tile_start;
   logic        w_starve;
   logic        w_stage_clr;
   logic [15:0] w_stage_row;
   logic [7:0]  w_stage_code;
   logic        w_stage_flip;
   logic        w_stage_valid;
   logic [15:0] w_row;
   logic [7:0]  w_code;
   logic        w_flip;
   logic [2:0]  w_idx;
   logic [1:0]  w_color;
   logic [15:0] r_cur_row;
   logic [7:0]  r_cur_code;
   logic        r_cur_flip;

   assign w_next_line = (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
   assign w_trig_a    = pix_en && (DrawY < Y_ACT) && (DrawX[2:0] == 3'd0) && (DrawX < X_TRIG);
   assign w_trig_b    = pix_en && (DrawX == X_PRE) && (w_next_line < Y_ACT);
   assign w_trig      = w_trig_a || w_trig_b;
   assign w_req_col   = w_trig_a ? DrawX[9:3] + 7'd1 : 7'd0;
   assign w_req_line  = w_trig_a ? DrawY[8:0] : w_next_line[8:0];
   assign w_drop      = w_trig && w_busy;

   assign w_active     = (DrawX < X_ACT) && (DrawY < Y_ACT);
   assign w_tile_start = (DrawX[2:0] == 3'd0);
   assign w_starve     = w_active && w_tile_start && !w_stage_valid;
   assign w_stage_clr  = pix_en && w_active && w_tile_start;

   tile_row_fetch #(
      .MAP_BASE (MAP_BASE)
   ) u_fetch (
      .i_clk         (Clk),
      .i_reset       (Reset),
      .i_req         (w_trig),
      .i_col         (w_req_col),
      .i_line        (w_req_line),
      .i_stage_clr   (w_stage_clr),
      .i_map_rdata   (map_rdata),
      .i_pat_rdata   (pat_rdata),
      .o_busy        (w_busy),
      .o_map_addr    (map_addr),
      .o_pat_addr    (pat_addr),
      .o_stage_row   (w_stage_row),
      .o_stage_code  (w_stage_code),
      .o_stage_flip  (w_stage_flip),
      .o_stage_valid (w_stage_valid)
   );

   always_comb begin
      w_row  = r_cur_row;
      w_code = r_cur_code;
      w_flip = r_cur_flip;
      if (w_tile_start) begin
         w_row  = w_stage_row;
         w_code = w_stage_code;
         w_flip = w_stage_flip;
      end
      w_idx   = w_flip ? 3'd7 - DrawX[2:0] : DrawX[2:0];
      w_color = w_row[{w_idx, 1'b0} +: 2];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         extend_color   <= 2'd0;
         export_pattern <= 8'd0;
         pix_valid      <= 1'b0;
         underrun       <= 1'b0;
         r_cur_row      <= 16'd0;
         r_cur_code     <= 8'd0;
         r_cur_flip     <= 1'b0;
      end else begin
         if (pix_en) begin
            if (w_active) begin
               pix_valid      <= 1'b1;
               extend_color   <= w_starve ? 2'd0 : w_color;
               export_pattern <= w_starve ? 8'd0 : w_code;
               if (w_tile_start) begin
                  r_cur_row  <= w_stage_row;
                  r_cur_code <= w_stage_code;
                  r_cur_flip <= w_stage_flip;
               end
            end else begin
               pix_valid      <= 1'b0;
               extend_color   <= 2'd0;
               export_pattern <= 8'd0;
            end
         end
         if (w_drop || (pix_en && w_starve)) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Directed bench for tile_pixel_fetch with synchronous map/pattern memory models.
// TILE_HFLIP_EN adds the mirrored-tile case.
module tb_tile_pixel_fetch;
   import tile_pkg::*;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              pix_en;
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic [12:0]       map_addr;
   logic [MAP_DW-1:0] map_rdata;
   logic [10:0]       pat_addr;
   logic [15:0]       pat_rdata;
   logic [1:0]        extend_color;
   logic [7:0]        export_pattern;
   logic              pix_valid;
   logic              underrun;

   int n_total = 0;
   int n_bad   = 0;

   logic [MAP_DW-1:0] map_mem [8192];
   logic [15:0]       pat_mem [2048];

   int exp_e4 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef TILE_HFLIP_EN
   int exp_fl [8] = '{3, 2, 1, 0, 3, 2, 1, 0};
`endif

   tile_pixel_fetch #(
      .MAP_BASE   (13'd0),
      .PREFETCH_X (792)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .pix_en         (pix_en),
      .DrawX          (DrawX),
      .DrawY          (DrawY),
      .map_addr       (map_addr),
      .map_rdata      (map_rdata),
      .pat_addr       (pat_addr),
      .pat_rdata      (pat_rdata),
      .extend_color   (extend_color),
      .export_pattern (export_pattern),
      .pix_valid      (pix_valid),
      .underrun       (underrun)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      map_rdata <= map_mem[map_addr];
      pat_rdata <= pat_mem[pat_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // One pix_en pulse; outputs for this pixel are visible on return
   task automatic pix(input int x, input int y);
      @(negedge Clk);
      DrawX  = 10'(x);
      DrawY  = 10'(y);
      pix_en = 1'b1;
      @(negedge Clk);
      pix_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) map_mem[i] = '0;
      for (int i = 0; i < 2048; i++) pat_mem[i] = '0;
      map_mem[0]      = 'h05;
      map_mem[80]     = 'h21;
      pat_mem[11'h028] = 16'hE4E4;
      pat_mem[11'h108] = 16'h1B1B;

      Reset  = 1'b1;
      pix_en = 1'b0;
      DrawX  = '0;
      DrawY  = '0;
      idle(3);
      chk("rst_color", 32'(extend_color), 32'd0);
      chk("rst_code", 32'(export_pattern), 32'd0);
      chk("rst_valid", 32'(pix_valid), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_map_addr", 32'(map_addr), 32'd0);
      chk("rst_pat_addr", 32'(pat_addr), 32'd0);
      Reset = 1'b0;
      idle(2);

      // Prefetch line 0 from the last line's hblank, then draw tile 0
      pix(792, 524);
      chk("blank_valid", 32'(pix_valid), 32'd0);
      chk("blank_color", 32'(extend_color), 32'd0);
      idle(4);
      for (int i = 0; i < 8; i++) begin
         pix(i, 0);
         chk($sformatf("l0_color_%0d", i), 32'(extend_color), 32'(exp_e4[i]));
         chk($sformatf("l0_code_%0d", i), 32'(export_pattern), 32'h05);
         chk($sformatf("l0_valid_%0d", i), 32'(pix_valid), 32'd1);
      end
      chk("l0_underrun", 32'(underrun), 32'd0);

      // Line 7 -> 8 prefetch addresses map row 1
      pix(792, 7);
      chk("l8_map_addr", 32'(map_addr), 32'd80);
      idle(4);
      chk("l8_pat_addr", 32'(pat_addr), 32'h108);
      pix(0, 8);
      chk("l8_color_0", 32'(extend_color), 32'd3);
      chk("l8_code_0", 32'(export_pattern), 32'h21);
      pix(1, 8);
      chk("l8_color_1", 32'(extend_color), 32'd2);
      idle(4);

      // DrawX=632 is past the last in-line trigger
      pix(632, 8);
      chk("x632_no_fetch", 32'(map_addr), 32'd81);
      chk("x632_underrun", 32'(underrun), 32'd0);

      // No prefetch for line 480
      pix(792, 479);
      chk("y479_valid", 32'(pix_valid), 32'd0);
      idle(4);
      chk("y479_no_fetch", 32'(map_addr), 32'd81);
      pix(3, 500);
      chk("vblank_valid", 32'(pix_valid), 32'd0);
      chk("vblank_color", 32'(extend_color), 32'd0);
      chk("vblank_code", 32'(export_pattern), 32'd0);

      // Back-to-back pix_en: the hblank trigger lands while the FSM is busy
      pix(792, 524);
      idle(4);
      chk("pre_busy_underrun", 32'(underrun), 32'd0);
      @(negedge Clk);
      DrawX  = 10'd0;
      DrawY  = 10'd0;
      pix_en = 1'b1;
      @(negedge Clk);
      DrawX  = 10'd792;
      chk("busy_code_x0", 32'(export_pattern), 32'h05);
      @(negedge Clk);
      pix_en = 1'b0;
      chk("busy_underrun", 32'(underrun), 32'd1);
      chk("busy_map_addr", 32'(map_addr), 32'd1);
      chk("busy_blank_valid", 32'(pix_valid), 32'd0);
      idle(4);
      pix(1, 0);
      chk("busy_after_color", 32'(extend_color), 32'd1);
      chk("underrun_sticky", 32'(underrun), 32'd1);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("underrun_rst", 32'(underrun), 32'd0);

      // Reset landing in MAP_REQ aborts the fetch
      @(negedge Clk);
      DrawX  = 10'd792;
      DrawY  = 10'd7;
      pix_en = 1'b1;
      @(negedge Clk);
      pix_en = 1'b0;
      chk("mid_map_addr", 32'(map_addr), 32'd80);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("mid_rst_map_addr", 32'(map_addr), 32'd0);
      chk("mid_rst_pat_addr", 32'(pat_addr), 32'd0);
      chk("mid_rst_color", 32'(extend_color), 32'd0);
      chk("mid_rst_code", 32'(export_pattern), 32'd0);
      chk("mid_rst_valid", 32'(pix_valid), 32'd0);
      idle(5);
      chk("mid_rst_fsm_idle", 32'(pat_addr), 32'd0);
      pix(0, 8);
      chk("starve_underrun", 32'(underrun), 32'd1);
      chk("starve_color", 32'(extend_color), 32'd0);
      chk("starve_code", 32'(export_pattern), 32'd0);
      chk("starve_valid", 32'(pix_valid), 32'd1);

`ifdef TILE_HFLIP_EN
      map_mem[0] = 'h105;
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      pix(792, 524);
      idle(4);
      for (int i = 0; i < 8; i++) begin
         pix(i, 0);
         chk($sformatf("flip_color_%0d", i), 32'(extend_color), 32'(exp_fl[i]));
         chk($sformatf("flip_code_%0d", i), 32'(export_pattern), 32'h05);
      end
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
